// File: rtl/dram_mux_pkg.sv
// rtl/dram_mux_pkg.sv - shared types and helpers for the DRAM address mux sequencer
package dram_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    PRE  = 2'd3
  } state_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Lowest bit of channel ch's {row,col} field inside the flattened address bus.
  function automatic int addr_lo(input int ch, input int rw);
    return ch * 2 * rw;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request after the last grant
module rr_arbiter
  import dram_mux_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0]         req_i,
  input  logic [ch_w(NCH)-1:0]   last_i,
  output logic [ch_w(NCH)-1:0]   grant_o,
  output logic                   valid_o
);

  localparam int CH_W = ch_w(NCH);

  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    for (int i = 1; i <= NCH; i++) begin
      if (!valid_o && req_i[(int'(last_i) + i) % NCH]) begin
        valid_o = 1'b1;
        grant_o = CH_W'((int'(last_i) + i) % NCH);
      end
    end
  end

endmodule

// File: rtl/dram_addr_mux_seq.sv
// rtl/dram_addr_mux_seq.sv - arbitrated row/column DRAM address mux with RAS/CAS/WE timing
module dram_addr_mux_seq
  import dram_mux_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int RW        = 8,
  parameter int T_RAS_CAS = 1,
  parameter int T_CAS     = 2,
  parameter int T_PRE     = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  g_ni,
  input  logic [NCH-1:0]        req_i,
  input  logic [NCH-1:0]        wr_i,
  input  logic [NCH*2*RW-1:0]   addr_i,
  output logic [NCH-1:0]        ack_o,
  output logic [RW-1:0]         ma_o,
  output logic                  ras_n_o,
  output logic                  cas_n_o,
  output logic                  we_n_o,
  output logic                  busy_o
);

  localparam int CH_W  = ch_w(NCH);
  localparam int CNT_W = $clog2(max3(T_RAS_CAS, T_CAS, T_PRE) + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*RW-1:0]   addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [RW-1:0]     ma_q, ma_d;
  logic              ras_n_q, ras_n_d;
  logic              cas_n_q, cas_n_d;
  logic              we_n_q, we_n_d;
  logic [NCH-1:0]    ack_q, ack_d;
  logic              busy_q, busy_d;

  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_vld;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req_i   (req_i),
    .last_i  (last_q),
    .grant_o (gnt_idx),
    .valid_o (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (!g_ni && gnt_vld) begin
          state_d = ROW;
          cnt_d   = CNT_W'(T_RAS_CAS - 1);
          addr_d  = addr_i[addr_lo(int'(gnt_idx), RW) +: 2*RW];
          wr_d    = wr_i[gnt_idx];
          idx_d   = gnt_idx;
        end
      end
      ROW: begin
        if (cnt_q == '0) begin
          state_d = COL;
          cnt_d   = CNT_W'(T_CAS - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COL: begin
        if (cnt_q == '0) begin
          state_d = PRE;
          cnt_d   = CNT_W'(T_PRE - 1);
          last_d  = idx_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    ma_d    = '0;
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    ack_d   = '0;
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      ROW: begin
        ma_d    = addr_d[2*RW-1:RW];
        ras_n_d = 1'b0;
      end
      COL: begin
        ma_d    = addr_d[RW-1:0];
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        we_n_d  = ~wr_d;
        if (cnt_d == '0) ack_d[idx_d] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      last_q  <= CH_W'(NCH - 1);
      ma_q    <= '0;
      ras_n_q <= 1'b1;
      cas_n_q <= 1'b1;
      we_n_q  <= 1'b1;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ma_q    <= ma_d;
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign ma_o    = ma_q;
  assign ras_n_o = ras_n_q;
  assign cas_n_o = cas_n_q;
  assign we_n_o  = we_n_q;
  assign ack_o   = ack_q;
  assign busy_o  = busy_q;

endmodule
